hv_memory_writer: RTL and testbench
===================================

Name: hv_memory_writer

Overview:
Streaming writer that loads one hypervector segment into the shared dual-port RAM, so the similarity mapper can later read it back.
- Accepts a framed word stream (valid/first/last with ready backpressure) and writes word i to RAM address hv_base + i, for i = hv_start..hv_end.
- Command handshake matches the similarity mapper: valid is held high, done is returned and held, then valid is dropped.
- Sits between the encoder/host stream and the dpRam write port.

Parameters:
HV_DATA_WIDTH, 32, RAM word width and stream data width
HV_ADDRESS_WIDTH, 5, RAM address width

Ports:
clk  input  1  system clock; one clock domain
reset_n  input  1  asynchronous, active-low reset
valid  input  1  command request, held high until done is observed
hv_base  input  HV_ADDRESS_WIDTH  base RAM address of the hypervector
hv_start  input  HV_ADDRESS_WIDTH  first word index to write
hv_end  input  HV_ADDRESS_WIDTH  last word index to write, inclusive
s_valid  input  1  stream beat valid
s_first  input  1  first beat of frame
s_last  input  1  last beat of frame
s_data  input  HV_DATA_WIDTH  stream data
s_ready  output  1  stream ready
we_n  output  1  RAM write enable, active low
address  output  HV_ADDRESS_WIDTH  RAM address
data_wr  output  HV_DATA_WIDTH  RAM write data
done  output  1  command complete, held while valid stays high
error  output  1  framing or length error for this command, valid while done=1
count  output  HV_ADDRESS_WIDTH+1  number of words written this command

Behaviour:
- Reset (async, any state): state=IDLE, we_n=1, address=0, data_wr=0, done=0, error=0, count=0, s_ready=0. A reset mid-command aborts it; no further writes are issued.
- Handshakes:
  - A beat is accepted at a clock edge when s_valid & s_ready.
  - s_ready is a combinational decode of state: high in WAIT_FIRST, WRITE and DRAIN only.
- All RAM outputs are registered.
  - A beat accepted at edge k drives we_n=0, address=hv_base+idx and data_wr=s_data from edge k up to edge k+1.
  - The RAM commits the word at edge k+1.
  - we_n returns to 1 at edge k+1 unless another beat is accepted at edge k+1. Back-to-back beats give 1 word/cycle.
- Address arithmetic: hv_base+idx is truncated to HV_ADDRESS_WIDTH, so it wraps modulo 2^HV_ADDRESS_WIDTH. idx is HV_ADDRESS_WIDTH wide.
- FSM states: IDLE, WAIT_FIRST, WRITE, DRAIN, FLUSH, DONE.
  - IDLE: on valid=1, latch hv_base/hv_start/hv_end, clear count and error.
    - If hv_start>hv_end: set error and go to DONE; no writes.
    - Otherwise: idx=hv_start, go to WAIT_FIRST.
  - WAIT_FIRST: accepted beats with s_first=0 are discarded, not written.
    - Beat with s_first=1: write it at idx.
    - If idx==hv_end, apply the end rules below; otherwise go to WRITE with idx+1.
  - WRITE: every accepted beat is written at idx and count increments.
    - s_first=1 mid-frame: the beat is still written; error is set.
    - End rules, applied to the last write cycle:
      - s_last=1 and idx==hv_end: go to FLUSH (normal completion).
      - s_last=1 and idx<hv_end (short frame): error=1, go to FLUSH.
      - idx==hv_end and s_last=0 (long frame): write the beat, error=1, go to DRAIN.
  - DRAIN: discard accepted beats until a beat with s_last=1 is accepted, then go to FLUSH. No writes in this state.
  - FLUSH: one cycle, s_ready=0, waits for the final write to commit. Next edge: done=1, go to DONE.
  - DONE: done=1, we_n=1, s_ready=0; count and error held. When valid=0: done=0, go to IDLE at the next edge.
- Latency: the final beat accepted at edge k gives done=1 from edge k+1, by which point the last word is committed in RAM.
- valid dropped before DONE: go to IDLE at the next edge.
  - A write already registered still completes.
  - Nothing is accepted after the abort; done is never raised.
- hv_* inputs may change after latching; the latched copies are used.

Decomposition:
- Package hv_mem_pkg (shared with the similarity direct mapper): writer state enum typedef, and address/count width helper constants derived from HV_ADDRESS_WIDTH.
- No sub-module is needed. The FSM and the write register stage live in one module.
- The bench reuses dpRamEmulator as the RAM model.

Test Plan:
1. hv_base=4, start=0, end=3; 4 back-to-back beats 0xA0..0xA3 (first on beat 0, last on beat 3) -> RAM[4..7]=A0..A3; done at edge 4 after the first accept; error=0; count=4.
2. Two s_first=0 beats 0xFF, then a 4-beat frame at base 0 with s_valid gapped every other cycle -> 0xFF never written; RAM[0..3] hold the frame; done; error=0.
3. start=0, end=3; frame of 2 beats (last on beat 1) -> RAM[0..1] written, RAM[2..3] unchanged; error=1; count=2. Separately, a 6-beat frame -> 4 words written, 2 drained; error=1; count=4.
4. hv_base=30, start=0, end=3 -> writes land at addresses 30, 31, 0, 1 in that order.
5. start=3, end=1 -> done=1 two cycles after valid rises; error=1; count=0; we_n stays high throughout.
6. reset_n low after 2 of 4 beats -> all outputs take reset values immediately; RAM holds only the 2 committed words. Separately, valid dropped mid-frame -> IDLE, no done, no further writes.

Source files
------------

// File: rtl/hv_mem_pkg.sv
// Shared types for the hypervector RAM writer and the similarity mapper.
// Width helpers keep address/count sizing consistent across both blocks.
package hv_mem_pkg;

   localparam int HV_DATA_W_DEF = 32;
   localparam int HV_ADDR_W_DEF = 5;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_FIRST,
      WRITE,
      DRAIN,
      FLUSH,
      DONE
   } hv_wr_state_e;

   // A full segment of 2^AW words needs one extra count bit.
   function automatic int hv_count_w(input int aw);
      return aw + 1;
   endfunction

   function automatic int hv_words(input int aw);
      return 1 << aw;
   endfunction

endpackage

// File: rtl/hv_memory_writer.sv
// Streams one framed hypervector segment into the dual-port RAM.
// Command side holds valid until done; all RAM-facing outputs are registered.
module hv_memory_writer
   import hv_mem_pkg::*;
#(
   parameter int HV_DATA_WIDTH    = HV_DATA_W_DEF,
   parameter int HV_ADDRESS_WIDTH = HV_ADDR_W_DEF
) (
   input  logic                                      clk,
   input  logic                                      reset_n,
   input  logic                                      valid,
   input  logic [HV_ADDRESS_WIDTH-1:0]               hv_base,
   input  logic [HV_ADDRESS_WIDTH-1:0]               hv_start,
   input  logic [HV_ADDRESS_WIDTH-1:0]               hv_end,
   input  logic                                      s_valid,
   input  logic                                      s_first,
   input  logic                                      s_last,
   input  logic [HV_DATA_WIDTH-1:0]                  s_data,
   output logic                                      s_ready,
   output logic                                      we_n,
   output logic [HV_ADDRESS_WIDTH-1:0]               address,
   output logic [HV_DATA_WIDTH-1:0]                  data_wr,
   output logic                                      done,
   output logic                                      error,
   output logic [hv_count_w(HV_ADDRESS_WIDTH)-1:0]   count
);

   localparam int AW = HV_ADDRESS_WIDTH;
   localparam int DW = HV_DATA_WIDTH;
   localparam int CW = hv_count_w(HV_ADDRESS_WIDTH);

   hv_wr_state_e state_q;

   logic [AW-1:0] base_q;
   logic [AW-1:0] end_q;
   logic [AW-1:0] idx_q;
   logic          we_n_q;
   logic [AW-1:0] address_q;
   logic [DW-1:0] data_q;
   logic          done_q;
   logic          error_q;
   logic [CW-1:0] count_q;

   logic          ready_d;
   logic          wr_beat_d;
   logic          at_end_d;
   logic          wr_err_d;
   logic [AW-1:0] wr_addr_d;
   logic [AW-1:0] idx_d;
   logic [CW-1:0] count_d;
   hv_wr_state_e  wr_next_d;

   always_comb begin
      ready_d = (state_q == WAIT_FIRST) ||
                (state_q == WRITE) ||
                (state_q == DRAIN);
   end

   // Beats seen after valid drops are never written, even if handshaken.
   always_comb begin
      wr_beat_d = 1'b0;
      if (valid && s_valid) begin
         unique case (state_q)
            WAIT_FIRST: wr_beat_d = s_first;
            WRITE:      wr_beat_d = 1'b1;
            default:    wr_beat_d = 1'b0;
         endcase
      end
   end

   always_comb begin
      at_end_d  = (idx_q == end_q);
      wr_addr_d = base_q + idx_q;
      idx_d     = idx_q + 1'b1;
      count_d   = count_q + 1'b1;
      wr_err_d  = (s_last && !at_end_d) ||
                  (!s_last && at_end_d) ||
                  ((state_q == WRITE) && s_first);
      if (s_last) begin
         wr_next_d = FLUSH;
      end else if (at_end_d) begin
         wr_next_d = DRAIN;
      end else begin
         wr_next_d = WRITE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         base_q    <= '0;
         end_q     <= '0;
         idx_q     <= '0;
         we_n_q    <= 1'b1;
         address_q <= '0;
         data_q    <= '0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         count_q   <= '0;
      end else begin
         we_n_q <= 1'b1;

         if (wr_beat_d) begin
            we_n_q    <= 1'b0;
            address_q <= wr_addr_d;
            data_q    <= s_data;
            idx_q     <= idx_d;
            count_q   <= count_d;
         end

         unique case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (valid) begin
                  base_q  <= hv_base;
                  end_q   <= hv_end;
                  idx_q   <= hv_start;
                  count_q <= '0;
                  if (hv_start > hv_end) begin
                     error_q <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     error_q <= 1'b0;
                     state_q <= WAIT_FIRST;
                  end
               end
            end
            WAIT_FIRST, WRITE: begin
               if (!valid) begin
                  state_q <= IDLE;
               end else if (wr_beat_d) begin
                  state_q <= wr_next_d;
                  if (wr_err_d) begin
                     error_q <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (!valid) begin
                  state_q <= IDLE;
               end else if (s_valid && s_last) begin
                  state_q <= FLUSH;
               end
            end
            FLUSH: begin
               if (!valid) begin
                  state_q <= IDLE;
               end else begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (!valid) begin
                  done_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  done_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign s_ready = ready_d;
   assign we_n    = we_n_q;
   assign address = address_q;
   assign data_wr = data_q;
   assign done    = done_q;
   assign error   = error_q;
   assign count   = count_q;

endmodule

// File: tb/tb_hv_memory_writer.sv
// Directed bench for hv_memory_writer with a behavioural dual-port RAM.
// Expected RAM contents and handshake timing are hand-derived per vector.
module tb_hv_memory_writer;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          valid;
   logic [AW-1:0] hv_base;
   logic [AW-1:0] hv_start;
   logic [AW-1:0] hv_end;
   logic          s_valid;
   logic          s_first;
   logic          s_last;
   logic [DW-1:0] s_data;
   logic          s_ready;
   logic          we_n;
   logic [AW-1:0] address;
   logic [DW-1:0] data_wr;
   logic          done;
   logic          error;
   logic [AW:0]   count;

   int n_checks = 0;
   int n_fail   = 0;

   hv_memory_writer #(
      .HV_DATA_WIDTH   (DW),
      .HV_ADDRESS_WIDTH(AW)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .valid   (valid),
      .hv_base (hv_base),
      .hv_start(hv_start),
      .hv_end  (hv_end),
      .s_valid (s_valid),
      .s_first (s_first),
      .s_last  (s_last),
      .s_data  (s_data),
      .s_ready (s_ready),
      .we_n    (we_n),
      .address (address),
      .data_wr (data_wr),
      .done    (done),
      .error   (error),
      .count   (count)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_word(input int i);
      return 32'h5A00_0000 | i;
   endfunction

   // RAM model: commits on the edge that ends a we_n=0 cycle.
   logic [DW-1:0] ram [32];
   bit            ram_ready = 1'b0;
   int            nwr = 0;
   int            nff = 0;
   logic [AW-1:0] wlog [$];

   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int i = 0; i < 32; i++) ram[i] <= init_word(i);
         ram_ready <= 1'b1;
      end else if (!we_n) begin
         ram[address] <= data_wr;
         wlog.push_back(address);
         nwr <= nwr + 1;
         if (data_wr == 32'hFF) nff <= nff + 1;
      end
   end

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      s_valid = 1'b0;
      s_first = 1'b0;
      s_last  = 1'b0;
   endtask

   // Returns 1 time unit after the edge that accepted the beat.
   task automatic beat(input logic [DW-1:0] d, input logic f,
                       input logic l, input int gap);
      int n;
      idle();
      repeat (gap) tick();
      s_valid = 1'b1;
      s_data  = d;
      s_first = f;
      s_last  = l;
      n = 0;
      while (!s_ready && n < 20) begin
         tick();
         n++;
      end
      check("beat_ready", s_ready, 1);
      tick();
   endtask

   task automatic start_cmd(input logic [AW-1:0] b, input logic [AW-1:0] st,
                            input logic [AW-1:0] en);
      hv_base  = b;
      hv_start = st;
      hv_end   = en;
      valid    = 1'b1;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (!done && n < 20) begin
         tick();
         n++;
      end
      check(tag, done, 1);
   endtask

   task automatic end_cmd(input string tag);
      valid = 1'b0;
      tick();
      check(tag, done, 0);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int w0;
      int q0;
      logic [AW-1:0] ea [4];
      ea = '{5'd30, 5'd31, 5'd0, 5'd1};

      reset_n  = 1'b0;
      valid    = 1'b0;
      hv_base  = '0;
      hv_start = '0;
      hv_end   = '0;
      s_data   = '0;
      idle();
      tick();
      tick();
      check("rst_we_n", we_n, 1);
      check("rst_ready", s_ready, 0);
      check("rst_done", done, 0);
      check("rst_count", count, 0);
      reset_n = 1'b1;
      tick();

      // 1: back-to-back frame at base 4
      start_cmd(5'd4, 5'd0, 5'd3);
      w0 = nwr;
      beat(32'hA0, 1, 0, 0);
      check("t1_we_n0", we_n, 0);
      check("t1_addr0", address, 4);
      check("t1_data0", data_wr, 32'hA0);
      beat(32'hA1, 0, 0, 0);
      beat(32'hA2, 0, 0, 0);
      hv_base = 5'd9;
      beat(32'hA3, 0, 1, 0);
      idle();
      check("t1_addr3", address, 7);
      check("t1_done_early", done, 0);
      tick();
      check("t1_done", done, 1);
      check("t1_error", error, 0);
      check("t1_count", count, 4);
      check("t1_we_n_idle", we_n, 1);
      for (int i = 0; i < 4; i++)
         check("t1_ram", ram[4+i], 32'hA0 + i);
      check("t1_nwr", nwr - w0, 4);
      end_cmd("t1_done_drop");

      // 2: leading non-first beats discarded, gapped frame
      start_cmd(5'd0, 5'd0, 5'd3);
      w0 = nwr;
      beat(32'hFF, 0, 0, 0);
      beat(32'hFF, 0, 0, 0);
      beat(32'hB0, 1, 0, 1);
      beat(32'hB1, 0, 0, 1);
      beat(32'hB2, 0, 0, 1);
      beat(32'hB3, 0, 1, 1);
      idle();
      wait_done("t2_done");
      check("t2_error", error, 0);
      check("t2_count", count, 4);
      check("t2_no_ff", nff, 0);
      check("t2_nwr", nwr - w0, 4);
      for (int i = 0; i < 4; i++)
         check("t2_ram", ram[i], 32'hB0 + i);
      end_cmd("t2_done_drop");

      // 3a: short frame
      start_cmd(5'd0, 5'd0, 5'd3);
      beat(32'hC0, 1, 0, 0);
      beat(32'hC1, 0, 1, 0);
      idle();
      wait_done("t3a_done");
      check("t3a_error", error, 1);
      check("t3a_count", count, 2);
      check("t3a_ram0", ram[0], 32'hC0);
      check("t3a_ram1", ram[1], 32'hC1);
      check("t3a_ram2", ram[2], 32'hB2);
      check("t3a_ram3", ram[3], 32'hB3);
      end_cmd("t3a_done_drop");

      // 3b: long frame, extra beats drained
      start_cmd(5'd16, 5'd0, 5'd3);
      w0 = nwr;
      beat(32'hD0, 1, 0, 0);
      for (int i = 1; i < 5; i++) beat(32'hD0 + i, 0, 0, 0);
      beat(32'hD5, 0, 1, 0);
      idle();
      wait_done("t3b_done");
      check("t3b_error", error, 1);
      check("t3b_count", count, 4);
      check("t3b_nwr", nwr - w0, 4);
      for (int i = 0; i < 4; i++)
         check("t3b_ram", ram[16+i], 32'hD0 + i);
      check("t3b_ram20", ram[20], init_word(20));
      check("t3b_ram21", ram[21], init_word(21));
      end_cmd("t3b_done_drop");

      // 4: address wrap
      start_cmd(5'd30, 5'd0, 5'd3);
      q0 = wlog.size();
      beat(32'hE0, 1, 0, 0);
      beat(32'hE1, 0, 0, 0);
      beat(32'hE2, 0, 0, 0);
      beat(32'hE3, 0, 1, 0);
      idle();
      wait_done("t4_done");
      check("t4_error", error, 0);
      check("t4_nlog", wlog.size() - q0, 4);
      for (int i = 0; i < 4; i++)
         check("t4_addr", wlog[q0+i], ea[i]);
      check("t4_ram0", ram[0], 32'hE2);
      check("t4_ram31", ram[31], 32'hE1);
      end_cmd("t4_done_drop");

      // 5: start > end
      start_cmd(5'd0, 5'd3, 5'd1);
      w0 = nwr;
      tick();
      check("t5_done_c1", done, 0);
      check("t5_ready", s_ready, 0);
      tick();
      check("t5_done_c2", done, 1);
      check("t5_error", error, 1);
      check("t5_count", count, 0);
      check("t5_we_n", we_n, 1);
      check("t5_nwr", nwr - w0, 0);
      end_cmd("t5_done_drop");

      // 6a: reset mid-frame
      start_cmd(5'd8, 5'd0, 5'd3);
      w0 = nwr;
      beat(32'hF0, 1, 0, 0);
      beat(32'hF1, 0, 0, 0);
      idle();
      check("t6a_count", count, 2);
      tick();
      s_valid = 1'b1;
      s_data  = 32'hF2;
      #1;
      reset_n = 1'b0;
      #1;
      check("t6a_we_n", we_n, 1);
      check("t6a_addr", address, 0);
      check("t6a_data", data_wr, 0);
      check("t6a_done", done, 0);
      check("t6a_error", error, 0);
      check("t6a_cnt_rst", count, 0);
      check("t6a_ready", s_ready, 0);
      tick();
      tick();
      tick();
      check("t6a_ram8", ram[8], 32'hF0);
      check("t6a_ram9", ram[9], 32'hF1);
      check("t6a_ram10", ram[10], init_word(10));
      check("t6a_nwr", nwr - w0, 2);
      idle();
      valid = 1'b0;
      reset_n = 1'b1;
      tick();

      // 6b: valid dropped mid-frame
      start_cmd(5'd24, 5'd0, 5'd3);
      w0 = nwr;
      beat(32'h10, 1, 0, 0);
      beat(32'h11, 0, 0, 0);
      idle();
      valid = 1'b0;
      tick();
      check("t6b_ready", s_ready, 0);
      check("t6b_we_n", we_n, 1);
      repeat (5) tick();
      check("t6b_done", done, 0);
      check("t6b_ram24", ram[24], 32'h10);
      check("t6b_ram25", ram[25], 32'h11);
      check("t6b_ram26", ram[26], init_word(26));
      check("t6b_nwr", nwr - w0, 2);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
